// File: rtl/soc_trace_termination_monitor.sv
// soc_trace_termination_monitor: per-core trace shadow, exit-code capture and global completion flag.
// Optional watchdog compiled in with SOC_TRACE_WATCHDOG_EN.
module soc_trace_termination_monitor #(
  parameter int          NUM_CORES = 4,
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 32,
  parameter int          REG_IDX   = 3,
  parameter logic [31:0] TERM_INSN = 32'h00100013,
  parameter int          TIMEOUT   = 1000000
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CORES-1:0]                         trace_valid,
  input  logic [NUM_CORES*XLEN-1:0]                    trace_pc,
  input  logic [NUM_CORES*32-1:0]                      trace_insn,
  input  logic [NUM_CORES-1:0]                         trace_wben,
  input  logic [NUM_CORES*5-1:0]                       trace_wbreg,
  input  logic [NUM_CORES*XLEN-1:0]                    trace_wbdata,
  input  logic [(NUM_CORES>1?$clog2(NUM_CORES):1)-1:0] query_sel,
  output logic [NUM_CORES-1:0]                         terminated,
  output logic                                         all_terminated,
  output logic                                         done_pulse,
  output logic                                         timeout,
  output logic [XLEN-1:0]                              query_exit_code,
  output logic [CNT_W-1:0]                             query_retired,
  output logic [XLEN-1:0]                              query_last_pc
);
  logic [XLEN-1:0]  exit_arr    [NUM_CORES];
  logic [XLEN-1:0]  last_pc_arr [NUM_CORES];
  logic [CNT_W-1:0] retired_arr [NUM_CORES];
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic             acc, wr, term;
    logic [XLEN-1:0]  shadow, exit_code, last_pc, nxt_shadow;
    logic [CNT_W-1:0] retired;
    assign acc = trace_valid[i] && !term;
    assign wr = trace_wben[i] && trace_wbreg[i*5 +: 5] == 5'(REG_IDX);
    // same-beat write-back is bypassed so the marker captures the fresh value
    assign nxt_shadow = wr ? trace_wbdata[i*XLEN +: XLEN] : shadow;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        term      <= 1'b0;
        shadow    <= '0;
        exit_code <= '0;
        last_pc   <= '0;
        retired   <= '0;
      end else if (acc) begin
        retired <= &retired ? retired : retired + 1'b1;
        last_pc <= trace_pc[i*XLEN +: XLEN];
        shadow  <= nxt_shadow;
        if (trace_insn[i*32 +: 32] == TERM_INSN) begin
          term      <= 1'b1;
          exit_code <= nxt_shadow;
        end
      end
    assign terminated[i]  = term;
    assign exit_arr[i]    = exit_code;
    assign last_pc_arr[i] = last_pc;
    assign retired_arr[i] = retired;
  end
  logic sel_ok;
  assign sel_ok          = 32'(query_sel) < NUM_CORES;
  assign query_exit_code = sel_ok ? exit_arr[query_sel] : '0;
  assign query_retired   = sel_ok ? retired_arr[query_sel] : '0;
  assign query_last_pc   = sel_ok ? last_pc_arr[query_sel] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      all_terminated <= 1'b0;
      done_pulse     <= 1'b0;
    end else begin
      all_terminated <= &terminated;
      done_pulse     <= &terminated && !all_terminated;
    end
`ifdef SOC_TRACE_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else if (!all_terminated) begin
      if (|(trace_valid & ~terminated)) wd <= '0;
      else if (wd != TW'(TIMEOUT)) begin
        wd <= wd + 1'b1;
        if (wd == TW'(TIMEOUT - 1)) timeout <= 1'b1;
      end
    end
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_soc_trace_termination_monitor.sv
// tb_soc_trace_termination_monitor: directed vectors with hand-computed expectations.
module tb_soc_trace_termination_monitor;
  localparam logic [31:0] TERM = 32'h00100013;
  localparam logic [31:0] NOP  = 32'h00000013;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   trace_valid = '0;
  logic [127:0] trace_pc = '0;
  logic [127:0] trace_insn = '0;
  logic [3:0]   trace_wben = '0;
  logic [19:0]  trace_wbreg = '0;
  logic [127:0] trace_wbdata = '0;
  logic [1:0]   query_sel = '0;
  logic [3:0]   terminated;
  logic         all_terminated, done_pulse, timeout;
  logic [31:0]  query_exit_code, query_last_pc;
  logic [3:0]   query_retired;
  int tests = 0;
  int fails = 0;
  logic done_seen;

  soc_trace_termination_monitor #(.NUM_CORES(4), .XLEN(32), .CNT_W(4), .REG_IDX(3),
    .TERM_INSN(TERM), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_insn(trace_insn), .trace_wben(trace_wben), .trace_wbreg(trace_wbreg),
    .trace_wbdata(trace_wbdata), .query_sel(query_sel), .terminated(terminated),
    .all_terminated(all_terminated), .done_pulse(done_pulse), .timeout(timeout),
    .query_exit_code(query_exit_code), .query_retired(query_retired),
    .query_last_pc(query_last_pc));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    trace_valid = '0;
    trace_wben  = '0;
  endtask

  task automatic set_core(input int c, input logic [31:0] pc, input logic [31:0] insn,
                          input logic wb, input logic [4:0] r, input logic [31:0] d);
    trace_valid[c]          = 1'b1;
    trace_pc[c*32 +: 32]    = pc;
    trace_insn[c*32 +: 32]  = insn;
    trace_wben[c]           = wb;
    trace_wbreg[c*5 +: 5]   = r;
    trace_wbdata[c*32 +: 32] = d;
  endtask

  task automatic beat(input int c, input logic [31:0] pc, input logic [31:0] insn,
                      input logic wb, input logic [4:0] r, input logic [31:0] d);
    set_core(c, pc, insn, wb, r, d);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_term"}, 64'(terminated), 0);
    check({tag, "_all"}, 64'(all_terminated), 0);
    check({tag, "_done"}, 64'(done_pulse), 0);
    check({tag, "_tmo"}, 64'(timeout), 0);
    check({tag, "_exit"}, 64'(query_exit_code), 0);
    check({tag, "_ret"}, 64'(query_retired), 0);
    check({tag, "_pc"}, 64'(query_last_pc), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      done_seen |= done_pulse;
    end
    check("idle_done_seen", 64'(done_seen), 0);
    check_all_zero("idle");
`ifdef SOC_TRACE_WATCHDOG_EN
    repeat (79) tick();
    check("wd_before", 64'(timeout), 0);
    tick();
    check("wd_at_limit", 64'(timeout), 1);
    repeat (5) tick();
    check("wd_sticky", 64'(timeout), 1);
`else
    repeat (120) tick();
    check("no_wd", 64'(timeout), 0);
`endif
    #3 rst_n = 1'b0;
    #1;
    check("midrst_tmo", 64'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // core 2: x3 write, idle cycle, then marker
    query_sel = 2'd2;
    beat(2, 32'h100, NOP, 1'b1, 5'd3, 32'h2A);
    tick();
    check("c2_term_pre", 64'(terminated), 0);
    beat(2, 32'h104, TERM, 1'b0, 5'd0, 32'h0);
    check("c2_term", 64'(terminated), 4'b0100);
    check("c2_all", 64'(all_terminated), 0);
    check("c2_exit", 64'(query_exit_code), 32'h2A);
    check("c2_ret", 64'(query_retired), 2);
    check("c2_pc", 64'(query_last_pc), 32'h104);
    // core 0: marker with same-beat write to x3
    query_sel = 2'd0;
    #1;
    check("sel_comb_exit", 64'(query_exit_code), 0);
    beat(0, 32'h200, TERM, 1'b1, 5'd3, 32'h7);
    check("c0_term", 64'(terminated), 4'b0101);
    check("c0_bypass", 64'(query_exit_code), 32'h7);
    beat(0, 32'h300, NOP, 1'b1, 5'd3, 32'h99);
    check("c0_frz_ret", 64'(query_retired), 1);
    check("c0_frz_pc", 64'(query_last_pc), 32'h200);
    check("c0_frz_exit", 64'(query_exit_code), 32'h7);
    // core 1: x0 write then 19 more retirements (counter saturates at 15)
    query_sel = 2'd1;
    beat(1, 32'h1000, NOP, 1'b1, 5'd0, 32'h99);
    for (int k = 1; k < 20; k++) beat(1, 32'h1000 + 32'(4 * k), NOP, 1'b0, 5'd0, 32'h0);
    check("c1_sat", 64'(query_retired), 15);
    check("c1_pc", 64'(query_last_pc), 32'h104C);
    beat(3, 32'h3000, NOP, 1'b1, 5'd3, 32'h33);
    // cores 1 and 3 terminate together
    set_core(1, 32'h1050, TERM, 1'b0, 5'd0, 32'h0);
    set_core(3, 32'h3004, TERM, 1'b0, 5'd0, 32'h0);
    tick();
    check("both_term", 64'(terminated), 4'b1111);
    check("n1_all", 64'(all_terminated), 0);
    check("n1_done", 64'(done_pulse), 0);
    check("c1_x0_exit", 64'(query_exit_code), 0);
    check("c1_sat_term", 64'(query_retired), 15);
    tick();
    check("n2_all", 64'(all_terminated), 1);
    check("n2_done", 64'(done_pulse), 1);
    tick();
    check("n3_all", 64'(all_terminated), 1);
    check("n3_done", 64'(done_pulse), 0);
    query_sel = 2'd3;
    #1;
    check("c3_exit", 64'(query_exit_code), 32'h33);
    check("c3_ret", 64'(query_retired), 2);
    check("c3_pc", 64'(query_last_pc), 32'h3004);
    repeat (150) tick();
    check("post_done_tmo", 64'(timeout), 0);
    check("post_done_pulse", 64'(done_pulse), 0);
    // asynchronous reset mid-cycle clears sticky state
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
